// File: rtl/hilo_mac_unit.sv
// rtl/hilo_mac_unit.sv - HI/LO multiply-accumulate and move unit for the execute stage
// Radix-2^STEP iterative multiplier into {HI,LO} with single-cycle mthi/mtlo moves.
module hilo_mac_unit #(
  parameter int STEP = 4
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ValidIn,
  input  logic        MoveIn,
  input  logic        HiOrLoIn,
  input  logic        SignedIn,
  input  logic        MaddIn,
  input  logic        MsubIn,
  input  logic [31:0] AIn,
  input  logic [31:0] BIn,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  localparam int N  = 32 / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t        state, nextState;
  logic [CW-1:0] iterCnt;
  logic [63:0]   aShift;
  logic [31:0]   bShift;
  logic [63:0]   partial;
  logic          maddQ, msubQ, negQ;

  logic          accept, lastIter;
  logic [31:0]   aMag, bMag;
  logic [63:0]   digitExt, digitProd, prodSigned, hiLo, result;

  assign accept   = ValidIn && (state == IDLE) && !Done;
  assign lastIter = (iterCnt == CW'(N - 1));

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign aMag = (SignedIn && AIn[31]) ? -AIn : AIn;
  assign bMag = (SignedIn && BIn[31]) ? -BIn : BIn;

  assign digitExt   = {{(64-STEP){1'b0}}, bShift[STEP-1:0]};
  assign digitProd  = aShift * digitExt;
  assign prodSigned = negQ ? -partial : partial;
  assign hiLo       = {HiOut, LoOut};
  assign result     = msubQ ? (hiLo - prodSigned) :
                      maddQ ? (hiLo + prodSigned) : prodSigned;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !MoveIn) nextState = MUL;
      MUL:     if (lastIter) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= nextState;
      Busy  <= (nextState != IDLE);
      Done  <= (state == FIN);
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      HiOut   <= '0;
      LoOut   <= '0;
      iterCnt <= '0;
      aShift  <= '0;
      bShift  <= '0;
      partial <= '0;
      maddQ   <= 1'b0;
      msubQ   <= 1'b0;
      negQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (MoveIn) begin
              if (HiOrLoIn) HiOut <= AIn;
              else          LoOut <= AIn;
            end else begin
              maddQ   <= MaddIn;
              msubQ   <= MsubIn;
              negQ    <= SignedIn & (AIn[31] ^ BIn[31]);
              aShift  <= {32'b0, aMag};
              bShift  <= bMag;
              partial <= '0;
              iterCnt <= '0;
            end
          end
        end
        MUL: begin
          partial <= partial + digitProd;
          aShift  <= aShift << STEP;
          bShift  <= bShift >> STEP;
          iterCnt <= iterCnt + CW'(1);
        end
        FIN: begin
          {HiOut, LoOut} <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb/tb_hilo_mac_unit.sv - scoreboard testbench for hilo_mac_unit
// Stimulus pushes expected {HI,LO} per multiply; a negedge monitor checks on every Done.
module tb_hilo_mac_unit;

  localparam int STEP = 4;
  localparam int N    = 32 / STEP;

  logic        Clk;
  logic        ResetN;
  logic        ValidIn, MoveIn, HiOrLoIn, SignedIn, MaddIn, MsubIn;
  logic [31:0] AIn, BIn;
  logic        Busy, Done;
  logic [31:0] HiOut, LoOut;

  int errors = 0;
  int checks = 0;
  logic [63:0] expQ[$];

  hilo_mac_unit #(.STEP(STEP)) dut (
    .Clk(Clk), .ResetN(ResetN), .ValidIn(ValidIn), .MoveIn(MoveIn),
    .HiOrLoIn(HiOrLoIn), .SignedIn(SignedIn), .MaddIn(MaddIn), .MsubIn(MsubIn),
    .AIn(AIn), .BIn(BIn), .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares HI/LO, Busy length and Done width on every Done pulse.
  initial begin
    int  busyRun;
    logic prevDone;
    busyRun  = 0;
    prevDone = 1'b0;
    forever begin
      @(negedge Clk);
      if (!ResetN) begin
        expQ.delete();
        busyRun  = 0;
        prevDone = 1'b0;
      end else begin
        if (Busy) busyRun++;
        if (Done) begin
          chk("done_one_cycle", {63'b0, prevDone}, 64'd0);
          if (expQ.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            chk("hi_result", {32'b0, HiOut}, {32'b0, e[63:32]});
            chk("lo_result", {32'b0, LoOut}, {32'b0, e[31:0]});
            chk("busy_cycles", 64'(busyRun), 64'(N + 1));
          end
          busyRun = 0;
        end
        prevDone = Done;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (!Done && k < 50) begin
      step();
      k++;
    end
    if (!Done) chk("done_timeout", 64'd1, 64'd0);
    else step();
  endtask

  task automatic move(input logic toHi, input logic [31:0] v);
    ValidIn = 1'b1; MoveIn = 1'b1; HiOrLoIn = toHi; AIn = v;
    step();
    ValidIn = 1'b0; MoveIn = 1'b0;
  endtask

  task automatic mul(input logic s, input logic ma, input logic ms,
                     input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    expQ.push_back(exp);
    ValidIn = 1'b1; MoveIn = 1'b0; SignedIn = s; MaddIn = ma; MsubIn = ms;
    AIn = a; BIn = b;
    step();
    ValidIn = 1'b0;
    waitDone();
  endtask

  initial begin
    ResetN = 1'b0; ValidIn = 1'b0; MoveIn = 1'b0; HiOrLoIn = 1'b0;
    SignedIn = 1'b0; MaddIn = 1'b0; MsubIn = 1'b0; AIn = '0; BIn = '0;
    repeat (2) step();
    chk("reset_hi", {32'b0, HiOut}, 64'd0);
    chk("reset_lo", {32'b0, LoOut}, 64'd0);
    chk("reset_busy", {63'b0, Busy}, 64'd0);
    chk("reset_done", {63'b0, Done}, 64'd0);
    ResetN = 1'b1;
    step();

    mul(1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB);
    mul(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    mul(1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);

    // Moves
    move(1'b1, 32'h12345678);
    chk("mthi_hi", {32'b0, HiOut}, 64'h12345678);
    chk("mthi_lo_kept", {32'b0, LoOut}, 64'h0);
    chk("mthi_busy", {63'b0, Busy}, 64'd0);
    ValidIn = 1'b1; MoveIn = 1'b1; HiOrLoIn = 1'b0; AIn = 32'hA;
    step();
    chk("mtlo_a", {32'b0, LoOut}, 64'hA);
    AIn = 32'hB;
    step();
    ValidIn = 1'b0; MoveIn = 1'b0;
    chk("mtlo_b", {32'b0, LoOut}, 64'hB);
    chk("mtlo_hi_kept", {32'b0, HiOut}, 64'h12345678);

    // Accumulate carry and borrow across the LO/HI boundary
    move(1'b0, 32'hFFFFFFFF);
    move(1'b1, 32'h0);
    mul(1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 64'h00000001_00000000);
    mul(1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 64'h00000000_FFFFFFFF);
    mul(1'b0, 1'b1, 1'b1, 32'd1, 32'd1, 64'h00000000_FFFFFFFE);

    // Held ValidIn through Busy and Done: a single accumulate
    move(1'b1, 32'h0);
    move(1'b0, 32'h0);
    expQ.push_back(64'd6);
    ValidIn = 1'b1; MoveIn = 1'b0; SignedIn = 1'b0; MaddIn = 1'b1; MsubIn = 1'b0;
    AIn = 32'd2; BIn = 32'd3;
    step();
    waitDone();
    ValidIn = 1'b0;
    repeat (12) step();
    chk("held1_lo", {32'b0, LoOut}, 64'd6);
    chk("held1_idle", {63'b0, Busy}, 64'd0);

    // Held one further cycle: a second madd is accepted
    move(1'b1, 32'h0);
    move(1'b0, 32'h0);
    expQ.push_back(64'd6);
    expQ.push_back(64'd12);
    ValidIn = 1'b1; MoveIn = 1'b0; MaddIn = 1'b1; AIn = 32'd2; BIn = 32'd3;
    step();
    waitDone();
    step();
    ValidIn = 1'b0;
    chk("held2_busy", {63'b0, Busy}, 64'd1);
    waitDone();
    repeat (12) step();
    chk("held2_lo", {32'b0, LoOut}, 64'd12);
    chk("queue_drained", 64'(expQ.size()), 64'd0);

    // Asynchronous reset in the middle of a multiply
    move(1'b1, $urandom());
    move(1'b0, $urandom() | 32'h1);
    ValidIn = 1'b1; MoveIn = 1'b0; SignedIn = 1'b1; MaddIn = 1'b1; MsubIn = 1'b0;
    AIn = 32'h1234; BIn = 32'h5678;
    step();
    ValidIn = 1'b0;
    repeat (3) step();
    chk("mid_mul_busy", {63'b0, Busy}, 64'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("async_reset_busy", {63'b0, Busy}, 64'd0);
    chk("async_reset_done", {63'b0, Done}, 64'd0);
    chk("async_reset_hi", {32'b0, HiOut}, 64'd0);
    chk("async_reset_lo", {32'b0, LoOut}, 64'd0);
    repeat (2) step();
    ResetN = 1'b1;
    repeat (15) step();
    chk("post_reset_idle", {63'b0, Busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
